// File: rtl/hit_vec_encoder.sv
// Two-stage pipelined priority encoder: IN_W-bit hit vector -> lowest set index, any-hit, multi-hit.
// Latency 2 cycles from accept edge to out_valid; throughput 1 vector/cycle; capacity 2 entries.
// Backpressure: out_ready low stalls S2, then S1; in_ready = s1_adv && !flush (no path from in_vec).
//
// Ports: clk, resetn (async active-low), flush (sync kill of in-flight entries),
//        in_valid/in_ready/in_vec (input handshake), out_valid/out_ready (output handshake),
//        out_idx (lowest set bit, 0 if none), out_hit (vector nonzero), out_multi (>1 bit set).
// Build option: define MULTI_HIT_CHECK_EN to build the multi-hit logic; otherwise out_multi is 0.
module hit_vec_encoder #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 6,
    parameter int GRP_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_idx,
    output logic             out_hit,
    output logic             out_multi
);
    localparam int NG   = IN_W / GRP_W;
    localparam int LO_W = $clog2(GRP_W);
    localparam int GI_W = OUT_W - LO_W;

    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !flush;

    // ---------------- stage 1: per-group reduction ----------------
    logic [NG-1:0]           c_any;
    logic [NG-1:0][LO_W-1:0] c_lo;
    logic [NG-1:0]           s1_any;
    logic [NG-1:0][LO_W-1:0] s1_lo;

    always_comb begin
        logic [GRP_W-1:0] grp;
        c_any = '0;
        c_lo  = '0;
        grp   = '0;
        for (int g = 0; g < NG; g++) begin
            grp      = in_vec[g*GRP_W +: GRP_W];
            c_any[g] = |grp;
            // Walk from the top so the lowest set bit wins.
            for (int j = GRP_W - 1; j >= 0; j--) begin
                if (grp[j]) begin
                    c_lo[g] = LO_W'(j);
                end
            end
        end
    end

`ifdef MULTI_HIT_CHECK_EN
    logic [NG-1:0] c_multi;
    logic [NG-1:0] s1_multi;

    // x & (x-1) clears the lowest set bit; anything left means two or more bits.
    always_comb begin
        c_multi = '0;
        for (int g = 0; g < NG; g++) begin
            c_multi[g] = |(in_vec[g*GRP_W +: GRP_W] & (in_vec[g*GRP_W +: GRP_W] - GRP_W'(1)));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_multi <= '0;
        end else if (in_valid && in_ready) begin
            s1_multi <= c_multi;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_any   <= '0;
            s1_lo    <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= in_valid && in_ready;
            end
            if (in_valid && in_ready) begin
                s1_any <= c_any;
                s1_lo  <= c_lo;
            end
        end
    end

    // ---------------- stage 2: pick lowest hitting group ----------------
    logic [OUT_W-1:0] n_idx;
    logic             n_hit;
    logic             n_multi;

    always_comb begin
        n_idx = '0;
        for (int g = NG - 1; g >= 0; g--) begin
            if (s1_any[g]) begin
                n_idx = {GI_W'(g), s1_lo[g]};
            end
        end
        n_hit = |s1_any;
`ifdef MULTI_HIT_CHECK_EN
        n_multi = (|s1_multi) || (|(s1_any & (s1_any - NG'(1))));
`else
        n_multi = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_hit   <= 1'b0;
            out_multi <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s2_adv) begin
                out_valid <= s1_valid;
            end
            // Data only moves when S2 may advance, so a stalled result stays put.
            if (s1_valid && s2_adv && !flush) begin
                out_idx   <= n_idx;
                out_hit   <= n_hit;
                out_multi <= n_multi;
            end
        end
    end

endmodule

// File: tb/tb_hit_vec_encoder.sv
module tb_hit_vec_encoder;

`ifdef MULTI_HIT_CHECK_EN
    localparam bit MULTI_EN = 1'b1;
`else
    localparam bit MULTI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // 64-bit instance
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_hit, out_multi;
    logic [63:0] in_vec = '0;
    logic [5:0]  out_idx;

    // 32-bit instance
    logic        flush32 = 1'b0, in_valid32 = 1'b0, out_ready32 = 1'b1;
    logic        in_ready32, out_valid32, out_hit32, out_multi32;
    logic [31:0] in_vec32 = '0;
    logic [4:0]  out_idx32;

    hit_vec_encoder #(.IN_W(64), .OUT_W(6), .GRP_W(8)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_hit(out_hit), .out_multi(out_multi)
    );

    hit_vec_encoder #(.IN_W(32), .OUT_W(5), .GRP_W(8)) dut32 (
        .clk(clk), .resetn(resetn), .flush(flush32),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_vec(in_vec32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .out_idx(out_idx32), .out_hit(out_hit32), .out_multi(out_multi32)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: count trailing zeros, popcount.
    function automatic int ref_idx(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic ref_multi(input logic [63:0] v);
        return MULTI_EN && ($countones(v) > 1);
    endfunction

    function automatic logic [63:0] rnd_vec(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 4))
            0: v = '0;
            1: v = 64'd1 << $urandom_range(0, w - 1);
            2: v = (64'd1 << $urandom_range(0, w - 1)) | (64'd1 << $urandom_range(0, w - 1));
            3: v = {$urandom, $urandom};
            default: v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        endcase
        if (w == 32) v[63:32] = '0;
        return v;
    endfunction

    // Scoreboards: vectors accepted but not yet delivered, in order.
    logic [63:0] q64[$];
    logic [63:0] q32[$];
    logic [63:0] v64, v32;

    always @(negedge clk) begin
        if (!resetn) begin
            q64.delete();
        end else begin
            chk("rdy64", in_ready, !flush && (q64.size() < 2 || out_ready));
            if (out_valid) chk("vld64_pending", q64.size() != 0, 1);
            if (flush) begin
                q64.delete();
            end else begin
                if (out_valid && out_ready && q64.size() != 0) begin
                    v64 = q64.pop_front();
                    chk("idx64", out_idx, ref_idx(v64));
                    chk("hit64", out_hit, v64 != 0);
                    chk("multi64", out_multi, ref_multi(v64));
                end
                if (in_valid && in_ready) q64.push_back(in_vec);
            end
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            q32.delete();
        end else begin
            chk("rdy32", in_ready32, !flush32 && (q32.size() < 2 || out_ready32));
            if (out_valid32) chk("vld32_pending", q32.size() != 0, 1);
            if (flush32) begin
                q32.delete();
            end else begin
                if (out_valid32 && out_ready32 && q32.size() != 0) begin
                    v32 = q32.pop_front();
                    chk("idx32", out_idx32, ref_idx(v32));
                    chk("hit32", out_hit32, v32 != 0);
                    chk("multi32", out_multi32, ref_multi(v32));
                end
                if (in_valid32 && in_ready32) q32.push_back({32'd0, in_vec32});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] v);
        in_vec   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_hit", out_hit, 0);
        chk("rst_out_multi", out_multi, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        resetn = 1'b1;
        tick();

        // Single hit, bit 37, latency 2 edges
        in_vec   = 64'h0000_0020_0000_0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_one_edge", out_valid, 0);
        tick();
        chk("b37_valid", out_valid, 1);
        chk("b37_idx", out_idx, 37);
        chk("b37_hit", out_hit, 1);
        chk("b37_multi", out_multi, 0);
        tick();

        // Sweep every single-bit position back to back
        for (int i = 0; i < 64; i++) begin
            in_vec   = 64'd1 << i;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();

        // Multi / no hit / same-group multi
        send((64'd1 << 9) | (64'd1 << 40));
        tick();
        chk("m940_idx", out_idx, 9);
        chk("m940_hit", out_hit, 1);
        chk("m940_multi", out_multi, MULTI_EN);
        send(64'd0);
        tick();
        chk("zero_idx", out_idx, 0);
        chk("zero_hit", out_hit, 0);
        chk("zero_multi", out_multi, 0);
        send(64'h6);
        tick();
        chk("m12_idx", out_idx, 1);
        chk("m12_multi", out_multi, MULTI_EN);
        tick();

        // Backpressure: capacity 2, stable output, ordered drain
        out_ready = 1'b0;
        in_vec = 64'd1 << 3;  in_valid = 1'b1;
        tick();
        in_vec = 64'd1 << 17;
        chk("bp_rdy_second", in_ready, 1);
        tick();
        in_vec = 64'd1 << 63;
        chk("bp_rdy_third", in_ready, 0);
        chk("bp_hold_idx", out_idx, 3);
        tick(); tick();
        chk("bp_still_full", in_ready, 0);
        chk("bp_still_idx", out_idx, 3);
        chk("bp_still_vld", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_drain_17", out_idx, 17);
        tick();
        chk("bp_drain_63", out_idx, 63);
        tick();
        chk("bp_drain_empty", out_valid, 0);

        // Flush with two entries in flight and in_valid high
        out_ready = 1'b0;
        send(64'd1 << 5);
        send(64'd1 << 6);
        in_vec = 64'd1 << 7; in_valid = 1'b1; flush = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_out_valid", out_valid, 0);
        tick();
        chk("fl_no_ghost", out_valid, 0);
        send(64'd1 << 12);
        chk("fl_after_lat1", out_valid, 0);
        tick();
        chk("fl_after_valid", out_valid, 1);
        chk("fl_after_idx", out_idx, 12);
        tick();

        // 32-bit instance: top bit
        in_vec32 = 32'h8000_0000; in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        tick();
        chk("w32_valid", out_valid32, 1);
        chk("w32_idx", out_idx32, 31);
        chk("w32_hit", out_hit32, 1);
        tick();

        // Reset mid-stream with both stages full
        out_ready = 1'b0;
        send(64'd1 << 10);
        send(64'd1 << 11);
        chk("rm_full", in_ready, 0);
        #2;
        resetn = 1'b0;
        #1;
        chk("rm_out_valid", out_valid, 0);
        chk("rm_out_idx", out_idx, 0);
        tick();
        resetn = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rm_in_ready", in_ready, 1);
        tick();
        chk("rm_no_stale", out_valid, 0);

        // Random regression on both widths
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_vec      = rnd_vec(64);
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 49) == 0);
            in_valid32  = ($urandom_range(0, 3) != 0);
            in_vec32    = rnd_vec(32)[31:0];
            out_ready32 = ($urandom_range(0, 9) < 6);
            flush32     = ($urandom_range(0, 49) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid32 = 1'b0; flush32 = 1'b0; out_ready32 = 1'b1;
        for (int k = 0; k < 20 && (q64.size() != 0 || q32.size() != 0); k++) tick();
        chk("drain64", q64.size(), 0);
        chk("drain32", q32.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
